// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes and debounces channels A/B, then turns
// Gray-code steps into one-clock up/down commands with illegal-jump accounting.

module quad_decoder_chan #(
    parameter int FILT_LEN = 3
) (
    input  logic clock,
    input  logic reset_,
    input  logic raw,
    input  logic load,
    input  logic run,
    output logic sync,
    output logic filt
);

    localparam logic [3:0] LAST_CNT = 4'(FILT_LEN - 1);

    logic       sync1_r;
    logic       sync2_r;
    logic       filt_r;
    logic [3:0] cnt_r;
    logic       filt_nxt_s;
    logic [3:0] cnt_nxt_s;

    // Two-flop synchronizer for the asynchronous encoder input
    always_ff @(negedge clock or negedge reset_) begin
        if (!reset_) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state: the filtered value follows only after FILT_LEN differing clocks
    always_comb begin
        filt_nxt_s = filt_r;
        cnt_nxt_s  = 4'd0;
        if (load) begin
            filt_nxt_s = sync2_r;
            cnt_nxt_s  = 4'd0;
        end else if (!run) begin
            filt_nxt_s = filt_r;
            cnt_nxt_s  = cnt_r;
        end else if (sync2_r == filt_r) begin
            cnt_nxt_s = 4'd0;
        end else if (cnt_r == LAST_CNT) begin
            filt_nxt_s = sync2_r;
            cnt_nxt_s  = 4'd0;
        end else begin
            cnt_nxt_s = cnt_r + 4'd1;
        end
    end

    // Debounce state register
    always_ff @(negedge clock or negedge reset_) begin
        if (!reset_) begin
            filt_r <= 1'b0;
            cnt_r  <= 4'd0;
        end else begin
            filt_r <= filt_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign sync = sync2_r;
    assign filt = filt_r;

endmodule

module quad_decoder #(
    parameter int FILT_LEN = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             ch_a,
    input  logic             ch_b,
    input  logic             enable,
    input  logic             err_clr,
    output logic [1:0]       up_dwn,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       init_cnt_r;
    logic [1:0]       init_cnt_nxt_s;
    logic             load_s;
    logic             run_s;
    logic             sync_a_s;
    logic             sync_b_s;
    logic             filt_a_s;
    logic             filt_b_s;
    logic [1:0]       cur_s;
    logic [1:0]       prev_r;
    logic [1:0]       dir_s;
    logic             illegal_s;
    logic [1:0]       up_dwn_r;
    logic             err_r;
    logic [ERR_W-1:0] err_cnt_r;

    // Successor of a Gray state when the encoder turns in the "up" direction
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        case (ab)
            2'b00:   fwd_next = 2'b01;
            2'b01:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b10;
            2'b10:   fwd_next = 2'b00;
            default: fwd_next = 2'b00;
        endcase
    endfunction

    quad_decoder_chan #(.FILT_LEN(FILT_LEN)) u_chan_a (
        .clock  (clock),
        .reset_ (reset_),
        .raw    (ch_a),
        .load   (load_s),
        .run    (run_s),
        .sync   (sync_a_s),
        .filt   (filt_a_s)
    );

    quad_decoder_chan #(.FILT_LEN(FILT_LEN)) u_chan_b (
        .clock  (clock),
        .reset_ (reset_),
        .raw    (ch_b),
        .load   (load_s),
        .run    (run_s),
        .sync   (sync_b_s),
        .filt   (filt_b_s)
    );

    assign run_s = (state_r == RUN);
    assign cur_s = {filt_a_s, filt_b_s};

    // Control FSM next-state: INIT waits for the synchronizers to fill, then snapshots
    always_comb begin
        state_nxt_s    = state_r;
        init_cnt_nxt_s = init_cnt_r;
        load_s         = 1'b0;
        case (state_r)
            INIT: begin
                if (init_cnt_r == 2'd2) begin
                    load_s         = 1'b1;
                    state_nxt_s    = RUN;
                    init_cnt_nxt_s = 2'd0;
                end else begin
                    init_cnt_nxt_s = init_cnt_r + 2'd1;
                end
            end
            RUN: begin
                state_nxt_s = RUN;
            end
            default: begin
                state_nxt_s    = INIT;
                init_cnt_nxt_s = 2'd0;
            end
        endcase
    end

    // Control FSM state register
    always_ff @(negedge clock or negedge reset_) begin
        if (!reset_) begin
            state_r    <= INIT;
            init_cnt_r <= 2'd0;
        end else begin
            state_r    <= state_nxt_s;
            init_cnt_r <= init_cnt_nxt_s;
        end
    end

    // Transition classifier: compares the previous filtered pair with the current one
    always_comb begin
        dir_s     = 2'b00;
        illegal_s = 1'b0;
        if (!run_s) begin
            dir_s = 2'b00;
        end else if (prev_r == cur_s) begin
            dir_s = 2'b00;
        end else if ((prev_r ^ cur_s) == 2'b11) begin
            illegal_s = 1'b1;
        end else if (cur_s == fwd_next(prev_r)) begin
            dir_s = 2'b01;
        end else begin
            dir_s = 2'b10;
        end
    end

    // Output and history registers; prev keeps tracking even while disabled
    always_ff @(negedge clock or negedge reset_) begin
        if (!reset_) begin
            prev_r    <= 2'b00;
            up_dwn_r  <= 2'b00;
            err_r     <= 1'b0;
            err_cnt_r <= {ERR_W{1'b0}};
        end else begin
            if (load_s) begin
                prev_r <= {sync_a_s, sync_b_s};
            end else if (run_s) begin
                prev_r <= cur_s;
            end else begin
                prev_r <= prev_r;
            end

            up_dwn_r <= enable ? dir_s : 2'b00;

            if (enable && illegal_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end

            if (enable && illegal_s && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign up_dwn  = up_dwn_r;
    assign err     = err_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (FILT_LEN=3, ERR_W=8): inputs change and outputs
// are checked on the rising edge, half a period away from the active falling edge.

module tb_quad_decoder;

    logic       clock;
    logic       reset_;
    logic       ch_a;
    logic       ch_b;
    logic       enable;
    logic       err_clr;
    logic [1:0] up_dwn;
    logic       err;
    logic [7:0] err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    quad_decoder #(.FILT_LEN(3), .ERR_W(8)) dut (
        .clock   (clock),
        .reset_  (reset_),
        .ch_a    (ch_a),
        .ch_b    (ch_b),
        .enable  (enable),
        .err_clr (err_clr),
        .up_dwn  (up_dwn),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run n falling edges; up_dwn must be d1 after edge k1, d2 after edge k2, else 00.
    task automatic edges(input int n, input logic [1:0] d1, input int k1,
                         input logic [1:0] d2, input int k2, input string tag);
        logic [1:0] exp_v;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            @(posedge clock);
            exp_v = (k == k1) ? d1 : ((k == k2) ? d2 : 2'b00);
            check($sformatf("%s up_dwn k=%0d", tag, k), {30'd0, up_dwn}, {30'd0, exp_v});
        end
    endtask

    task automatic step(input logic [1:0] ab, input int n, input logic [1:0] d, input int k,
                        input string tag);
        {ch_a, ch_b} = ab;
        edges(n, d, k, 2'b00, 0, tag);
    endtask

    task automatic check_err(input string tag, input logic e, input logic [7:0] c);
        check({tag, " err"}, {31'd0, err}, {31'd0, e});
        check({tag, " err_cnt"}, {24'd0, err_cnt}, {24'd0, c});
    endtask

    initial begin
        reset_  = 1'b0;
        ch_a    = 1'b0;
        ch_b    = 1'b0;
        enable  = 1'b1;
        err_clr = 1'b0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        check("reset up_dwn", {30'd0, up_dwn}, 32'd0);
        check_err("reset", 1'b0, 8'd0);
        reset_ = 1'b1;
        edges(10, 2'b00, 0, 2'b00, 0, "init00");

        // forward Gray steps: pulse 01 five edges after first sample
        step(2'b01, 10, 2'b01, 6, "fwd01");
        step(2'b11, 10, 2'b01, 6, "fwd11");
        step(2'b10, 10, 2'b01, 6, "fwd10");
        step(2'b00, 10, 2'b01, 6, "fwd00");
        check_err("fwd", 1'b0, 8'd0);

        step(2'b10, 10, 2'b10, 6, "rev10");
        step(2'b11, 10, 2'b10, 6, "rev11");
        step(2'b01, 10, 2'b10, 6, "rev01");
        step(2'b00, 10, 2'b10, 6, "rev00");
        check_err("rev", 1'b0, 8'd0);

        // glitch rejection and the 3-clock acceptance boundary
        step(2'b10, 2, 2'b00, 0, "glitchA2");
        step(2'b00, 10, 2'b00, 0, "glitchA2_back");
        step(2'b01, 2, 2'b00, 0, "glitchB2");
        step(2'b00, 10, 2'b00, 0, "glitchB2_back");
        {ch_a, ch_b} = 2'b10;
        edges(3, 2'b00, 0, 2'b00, 0, "pulseA3");
        {ch_a, ch_b} = 2'b00;
        edges(10, 2'b10, 3, 2'b01, 6, "pulseA3_back");
        step(2'b01, 10, 2'b01, 6, "holdB");
        step(2'b00, 10, 2'b10, 6, "holdB_back");

        // illegal jumps and sticky flag handling
        step(2'b11, 5, 2'b00, 0, "jump11a");
        check_err("pre_jump", 1'b0, 8'd0);
        edges(5, 2'b00, 0, 2'b00, 0, "jump11b");
        check_err("jump11", 1'b1, 8'd1);
        err_clr = 1'b1;
        edges(1, 2'b00, 0, 2'b00, 0, "clr");
        err_clr = 1'b0;
        check_err("clr", 1'b0, 8'd1);
        {ch_a, ch_b} = 2'b00;
        edges(5, 2'b00, 0, 2'b00, 0, "jump00a");
        err_clr = 1'b1;
        edges(1, 2'b00, 0, 2'b00, 0, "jump00_clr");
        err_clr = 1'b0;
        check_err("clr_vs_illegal", 1'b1, 8'd2);
        edges(4, 2'b00, 0, 2'b00, 0, "jump00b");

        // saturation of the error counter
        for (int i = 0; i < 252; i++) begin
            step((i % 2 == 0) ? 2'b11 : 2'b00, 8, 2'b00, 0, "sat_loop");
        end
        check_err("sat254", 1'b1, 8'd254);
        step(2'b11, 8, 2'b00, 0, "sat255");
        check_err("sat255", 1'b1, 8'd255);
        step(2'b00, 8, 2'b00, 0, "sat_hold");
        check_err("sat_hold", 1'b1, 8'd255);

        // reset with both channels high: INIT must not pulse
        reset_ = 1'b0;
        {ch_a, ch_b} = 2'b11;
        #1;
        check("async_rst up_dwn", {30'd0, up_dwn}, 32'd0);
        check_err("async_rst", 1'b0, 8'd0);
        edges(3, 2'b00, 0, 2'b00, 0, "rst11");
        reset_ = 1'b1;
        edges(10, 2'b00, 0, 2'b00, 0, "init11");
        check_err("init11", 1'b0, 8'd0);
        step(2'b10, 10, 2'b01, 6, "r11to10");

        // enable gating: transitions while disabled are absorbed silently
        step(2'b00, 10, 2'b01, 6, "en_fwd00");
        enable = 1'b0;
        step(2'b01, 10, 2'b00, 0, "dis01");
        step(2'b11, 10, 2'b00, 0, "dis11");
        step(2'b00, 10, 2'b00, 0, "dis_ill00");
        step(2'b11, 10, 2'b00, 0, "dis_ill11");
        check_err("disabled", 1'b0, 8'd0);
        enable = 1'b1;
        edges(10, 2'b00, 0, 2'b00, 0, "reenable");
        step(2'b10, 10, 2'b01, 6, "en11to10");
        step(2'b01, 10, 2'b00, 0, "en_ill01");
        check_err("en_ill", 1'b1, 8'd1);

        // reset asserted while a pulse is on the output
        {ch_a, ch_b} = 2'b11;
        edges(6, 2'b01, 6, 2'b00, 0, "mid_pulse");
        #2;
        reset_ = 1'b0;
        #1;
        check("mid_rst up_dwn", {30'd0, up_dwn}, 32'd0);
        check_err("mid_rst", 1'b0, 8'd0);
        @(negedge clock);
        @(posedge clock);
        reset_ = 1'b1;
        edges(10, 2'b00, 0, 2'b00, 0, "init_after_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
